// File: rtl/axi_lite_led_responder.sv
// == axi_lite_led_responder : AXI4-Lite slave with four RW registers driving a blinking LED bank ==
// == Rev 1.0 ==
`default_nettype none
`timescale 1ns/1ps

module axi_lite_led_responder #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int LED_WIDTH          = 4
) (
   input  logic                              ACLK,
   input  logic                              ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [LED_WIDTH-1:0]              LED
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = C_S_AXI_DATA_WIDTH / 8;

   localparam logic [1:0]    c_sel_led_val = 2'd0;
   localparam logic [1:0]    c_sel_mask    = 2'd1;
   localparam logic [1:0]    c_sel_period  = 2'd2;
   localparam logic [DW-1:0] c_one         = 1;

   logic                 aw_valid_q, aw_valid_d;
   logic [1:0]           aw_sel_q,   aw_sel_d;
   logic                 w_valid_q,  w_valid_d;
   logic [DW-1:0]        w_data_q,   w_data_d;
   logic [SW-1:0]        w_strb_q,   w_strb_d;
   logic                 bvalid_q,   bvalid_d;
   logic                 rvalid_q,   rvalid_d;
   logic [DW-1:0]        rdata_q,    rdata_d;
   logic [DW-1:0]        regs_q [4];
   logic [DW-1:0]        regs_d [4];
   logic [DW-1:0]        count_q,    count_d;
   logic                 phase_q,    phase_d;
   logic [LED_WIDTH-1:0] led_q,      led_d;

   logic aw_hs, w_hs, ar_hs, commit;

   logic unused_inputs;
   assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign aw_hs  = S_AXI_AWVALID & ~aw_valid_q;
   assign w_hs   = S_AXI_WVALID  & ~w_valid_q;
   assign ar_hs  = S_AXI_ARVALID & ~rvalid_q;
   // Both halves buffered and the previous response consumed: the write lands now.
   assign commit = aw_valid_q & w_valid_q & ~bvalid_q;

   always_comb begin
      aw_valid_d = aw_valid_q;
      aw_sel_d   = aw_sel_q;
      w_valid_d  = w_valid_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      bvalid_d   = bvalid_q;
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      count_d    = count_q;
      phase_d    = phase_q;
      for (int i = 0; i < 4; i++) begin
         regs_d[i] = regs_q[i];
      end

      if (aw_hs) begin
         aw_valid_d = 1'b1;
         aw_sel_d   = S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
         w_valid_d = 1'b1;
         w_data_d  = S_AXI_WDATA;
         w_strb_d  = S_AXI_WSTRB;
      end

      if (commit) begin
         aw_valid_d = 1'b0;
         w_valid_d  = 1'b0;
         bvalid_d   = 1'b1;
         for (int k = 0; k < SW; k++) begin
            if (w_strb_q[k]) begin
               regs_d[aw_sel_q][8*k +: 8] = w_data_q[8*k +: 8];
            end
         end
      end else if (bvalid_q && S_AXI_BREADY) begin
         bvalid_d = 1'b0;
      end

      // Reads sample the pre-commit register contents, so a colliding write is not visible yet.
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
      end else if (rvalid_q && S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end

      if (commit && (aw_sel_q == c_sel_period)) begin
         count_d = '0;
         phase_d = 1'b0;
      end else if (regs_q[c_sel_period] == '0) begin
         count_d = '0;
         phase_d = 1'b0;
      end else if (count_q == (regs_q[c_sel_period] - c_one)) begin
         count_d = '0;
         phase_d = ~phase_q;
      end else begin
         count_d = count_q + c_one;
      end

      led_d = regs_q[c_sel_led_val][LED_WIDTH-1:0]
            ^ (regs_q[c_sel_mask][LED_WIDTH-1:0] & {LED_WIDTH{phase_q}});
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         aw_valid_q <= 1'b0;
         aw_sel_q   <= '0;
         w_valid_q  <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         bvalid_q   <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         count_q    <= '0;
         phase_q    <= 1'b0;
         led_q      <= '0;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         aw_valid_q <= aw_valid_d;
         aw_sel_q   <= aw_sel_d;
         w_valid_q  <= w_valid_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         bvalid_q   <= bvalid_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         count_q    <= count_d;
         phase_q    <= phase_d;
         led_q      <= led_d;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign S_AXI_AWREADY = ~aw_valid_q;
   assign S_AXI_WREADY  = ~w_valid_q;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_ARREADY = ~rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;
   assign S_AXI_RVALID  = rvalid_q;
   assign LED           = led_q;

endmodule

`default_nettype wire
